video_scandbl_linebuf: RTL and testbench

- Line-doubling stage directly downstream of the palette/frame mixer.
- Captures the 6-bit {grn,red,blu} colour stream of each TV line (15.6 kHz) into one of two ping-pong line buffers.
- Replays the last completed line twice at VGA line rate (31.2 kHz), driven by VGA-side sync/strobe pulses.
- Both sides run in the single 28 MHz clk domain; rates differ only by strobes.

---
 rtl/video_scandbl_linebuf_pkg.sv | 19 +
 rtl/video_scandbl_ram.sv | 38 +++
 rtl/video_scandbl_linebuf.sv | 137 +++++++++++++
 tb/tb_video_scandbl_linebuf.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/video_scandbl_linebuf_pkg.sv
// Shared video pipeline constants and types for the scan-doubler line buffer
// and the palette stage feeding it.
package video_scandbl_linebuf_pkg;

  localparam int COLOR_W      = 6;
  localparam int ADDR_W_DEF   = 9;
  localparam int LINE_LEN_DEF = 448;

  // Colour word as produced by the palette stage: {grn, red, blu}.
  typedef logic [COLOR_W-1:0] color_t;

  // Per-clock record of a read request travelling through the RAM read register.
  typedef struct packed {
    logic req;    // a vga_pix_stb was seen
    logic hit;    // ... and it addressed written data
    logic blank;  // a vga_hsync_start was seen
  } rd_pipe_t;

endpackage

// File: rtl/video_scandbl_ram.sv
// Simple dual-port line RAM: two banks addressed {bank, addr}, synchronous
// write and registered read, in a form block-RAM inference recognises.
module video_scandbl_ram
  import video_scandbl_linebuf_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic            clk,
  input  logic            i_wr_en,
  input  logic [ADDR_W:0] i_wr_addr,
  input  color_t          i_wr_data,
  input  logic            i_rd_en,
  input  logic [ADDR_W:0] i_rd_addr,
  output color_t          o_rd_data
);

  localparam int DEPTH = 2 ** (ADDR_W + 1);

  color_t r_mem [0:DEPTH-1];
  color_t r_rd_data;

  // NOTE: the array and its read register have no reset; a reset would stop
  // the memory mapping onto block RAM, and every read is masked downstream.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/video_scandbl_linebuf.sv
// Scan-doubler line buffer: captures each TV line into a ping-pong bank and
// replays the last completed line at VGA line rate, all in one clock domain.
module video_scandbl_linebuf
  import video_scandbl_linebuf_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int LINE_LEN = LINE_LEN_DEF
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   tv_hsync_start,
  input  logic   tv_pix_stb,
  input  color_t color_in,
  input  logic   vga_hsync_start,
  input  logic   vga_pix_stb,
  output color_t vga_color,
  output logic   vga_valid,
  output logic   wr_bank,
  output logic   ovf
);

  localparam int PTR_W = ADDR_W + 1;
  typedef logic [PTR_W-1:0] ptr_t;
  localparam ptr_t LINE_LEN_P = ptr_t'(LINE_LEN);
  localparam ptr_t PTR_ONE    = ptr_t'(1);

  logic     r_wr_bank;
  logic     r_rd_bank;
  ptr_t     r_wptr;
  ptr_t     r_rptr;
  ptr_t     r_rlim;
  ptr_t     r_wcnt [2];
  logic     r_ovf;
  rd_pipe_t r_rd_pipe;
  color_t   r_vga_color;
  logic     r_vga_valid;

  logic            w_wr_bank_next;
  logic            w_done_bank;
  logic            w_wr_room;
  logic            w_wr_en;
  logic [ADDR_W:0] w_wr_addr;
  ptr_t            w_rlim_next;
  logic            w_rd_hit;
  logic            w_rd_en;
  logic [ADDR_W:0] w_rd_addr;
  color_t          w_rd_data;

  // The bank the write side uses this clock, and the one it has just finished.
  assign w_wr_bank_next = r_wr_bank ^ tv_hsync_start;
  assign w_done_bank    = ~w_wr_bank_next;

  // A pixel coinciding with the line start always fits: it lands at address 0.
  assign w_wr_room = (r_wptr < LINE_LEN_P);
  assign w_wr_en   = tv_pix_stb && (tv_hsync_start || w_wr_room);
  assign w_wr_addr = {w_wr_bank_next,
                      tv_hsync_start ? {ADDR_W{1'b0}} : r_wptr[ADDR_W-1:0]};

  // On a coincident TV line start the finished count is still in r_wptr.
  assign w_rlim_next = tv_hsync_start ? r_wptr : r_wcnt[w_done_bank];

  assign w_rd_hit  = (r_rptr < r_rlim);
  assign w_rd_en   = vga_pix_stb && w_rd_hit;
  assign w_rd_addr = {r_rd_bank, r_rptr[ADDR_W-1:0]};

  // NOTE: every register below is updated with non-blocking assignments so
  // all of them sample the same pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_bank <= 1'b0;
      r_wptr    <= '0;
      r_wcnt[0] <= '0;
      r_wcnt[1] <= '0;
      r_ovf     <= 1'b0;
    end else if (tv_hsync_start) begin
      r_wcnt[r_wr_bank] <= r_wptr;
      r_wr_bank         <= ~r_wr_bank;
      r_wptr            <= ptr_t'(tv_pix_stb);
    end else if (tv_pix_stb) begin
      if (w_wr_room) begin
        r_wptr <= r_wptr + PTR_ONE;
      end else begin
        r_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_bank <= 1'b1;
      r_rptr    <= '0;
      r_rlim    <= '0;
    end else if (vga_hsync_start) begin
      r_rd_bank <= w_done_bank;
      r_rptr    <= '0;
      r_rlim    <= w_rlim_next;
    end else if (w_rd_en) begin
      r_rptr <= r_rptr + PTR_ONE;
    end
  end

  // Second pipeline stage: an in-flight read wins over a pending line blank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_pipe   <= '0;
      r_vga_color <= '0;
      r_vga_valid <= 1'b0;
    end else begin
      r_rd_pipe <= '{req: vga_pix_stb, hit: w_rd_en, blank: vga_hsync_start};
      if (r_rd_pipe.req) begin
        r_vga_valid <= r_rd_pipe.hit;
        r_vga_color <= r_rd_pipe.hit ? w_rd_data : '0;
      end else if (r_rd_pipe.blank) begin
        r_vga_valid <= 1'b0;
        r_vga_color <= '0;
      end
    end
  end

  video_scandbl_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (color_in),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  assign vga_color = r_vga_color;
  assign vga_valid = r_vga_valid;
  assign wr_bank   = r_wr_bank;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_video_scandbl_linebuf.sv
// Directed bench for the scan-doubler line buffer: writes TV lines of known
// content and checks the doubled VGA replay against hand-derived values.
module tb_video_scandbl_linebuf;
  import video_scandbl_linebuf_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   tv_hsync_start = 1'b0;
  logic   tv_pix_stb = 1'b0;
  color_t color_in = '0;
  logic   vga_hsync_start = 1'b0;
  logic   vga_pix_stb = 1'b0;
  color_t vga_color;
  logic   vga_valid;
  logic   wr_bank;
  logic   ovf;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  video_scandbl_linebuf dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .tv_hsync_start  (tv_hsync_start),
    .tv_pix_stb      (tv_pix_stb),
    .color_in        (color_in),
    .vga_hsync_start (vga_hsync_start),
    .vga_pix_stb     (vga_pix_stb),
    .vga_color       (vga_color),
    .vga_valid       (vga_valid),
    .wr_bank         (wr_bank),
    .ovf             (ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: constant val; mode 1: pixel index; mode 2: 6'h3F first, then val.
  function automatic color_t exp_color(input int mode, input int k, input color_t val);
    case (mode)
      1:       return k[5:0];
      2:       return (k == 0) ? 6'h3F : val;
      default: return val;
    endcase
  endfunction

  task automatic tv_hs();
    tv_hsync_start = 1'b1;
    tick();
    tv_hsync_start = 1'b0;
  endtask

  task automatic tv_pixels(input int n, input int mode, input color_t val);
    for (int i = 0; i < n; i++) begin
      color_in   = exp_color(mode, i, val);
      tv_pix_stb = 1'b1;
      tick();
    end
    tv_pix_stb = 1'b0;
  endtask

  // Back-to-back strobes; strobe k is checked two edges after it is driven.
  task automatic vga_line(input string tag, input bit do_hs, input int n_stb,
                          input int n_valid, input int mode, input color_t val);
    logic   ev;
    color_t ec;
    if (do_hs) begin
      vga_hsync_start = 1'b1;
      tick();
      vga_hsync_start = 1'b0;
      tick();
      check({tag, "_blank"}, {vga_valid, vga_color}, 7'h00);
    end
    for (int i = 0; i <= n_stb; i++) begin
      vga_pix_stb = (i < n_stb);
      tick();
      if (i >= 1) begin
        ev = ((i - 1) < n_valid);
        ec = ev ? exp_color(mode, i - 1, val) : 6'h00;
        check($sformatf("%s[%0d]", tag, i - 1), {vga_valid, vga_color}, {ev, ec});
      end
    end
    vga_pix_stb = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    check("rst_color", vga_color, 0);
    check("rst_valid", vga_valid, 0);
    check("rst_wr_bank", wr_bank, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    tick();

    // Reset in the middle of a line
    tv_hs();
    check("pre_rst_wr_bank", wr_bank, 1);
    tv_pixels(5, 0, 6'h11);
    rst_n = 1'b0;
    #1;
    check("async_rst_wr_bank", wr_bank, 0);
    check("async_rst_out", {vga_valid, vga_color}, 0);
    tick();
    rst_n = 1'b1;
    vga_line("rst_line", 1'b1, 8, 0, 0, 6'h00);

    // Full-length line, replayed twice
    tv_hs();
    tv_pixels(448, 1, 6'h00);
    tv_hs();
    check("full_wr_bank", wr_bank, 0);
    vga_line("full_a", 1'b1, 448, 448, 1, 6'h00);
    vga_line("full_b", 1'b1, 448, 448, 1, 6'h00);

    // Short line read past its end
    tv_pixels(100, 0, 6'h2A);
    tv_hs();
    check("short_wr_bank", wr_bank, 1);
    vga_line("short", 1'b1, 120, 100, 0, 6'h2A);

    // Overlong line: ovf rises on the 449th strobe and stays set
    check("ovf_before", ovf, 0);
    for (int i = 0; i < 450; i++) begin
      color_in   = exp_color(1, i, 6'h00);
      tv_pix_stb = 1'b1;
      tick();
      if (i >= 446) check($sformatf("ovf_px%0d", i), ovf, (i >= 448) ? 1 : 0);
    end
    tv_pix_stb = 1'b0;
    tv_hs();
    vga_line("ovf_line", 1'b1, 450, 448, 1, 6'h00);
    check("ovf_sticky", ovf, 1);

    // TV line start, VGA line start and a pixel all in one clock
    tv_pixels(7, 0, 6'h15);
    color_in        = 6'h3F;
    tv_pix_stb      = 1'b1;
    tv_hsync_start  = 1'b1;
    vga_hsync_start = 1'b1;
    tick();
    tv_pix_stb      = 1'b0;
    tv_hsync_start  = 1'b0;
    vga_hsync_start = 1'b0;
    check("coin_wr_bank", wr_bank, 1);
    vga_line("coin", 1'b0, 9, 7, 0, 6'h15);
    tv_pixels(2, 0, 6'h0C);
    tv_hs();
    vga_line("coin_new", 1'b1, 4, 3, 2, 6'h0C);

    // TV side stalls: the last completed line repeats
    for (int l = 0; l < 10; l++) begin
      vga_line($sformatf("stall%0d", l), 1'b1, 5, 3, 2, 6'h0C);
      tv_pixels(3, 0, 6'h01);
    end
    check("stall_wr_bank", wr_bank, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
